// File: rtl/timer_alarm_core_pkg.sv
// Shared types and constants for the countdown alarm engine.
package timer_alarm_core_pkg;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } alarm_state_e;

    localparam logic MODE_ONE_SHOT = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // Period/remaining counters are twice the data width.
    function automatic int cnt_w(input int data_w);
        return 2 * data_w;
    endfunction
endpackage

// File: rtl/timer_alarm_core_if.sv
// Software-register side of the alarm: commands in, status out.
interface timer_alarm_core_if
    import timer_alarm_core_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PRESCALE_W = 16
);
    localparam int CNT_W = cnt_w(DATA_W);

    logic                  ALARM_START;
    logic                  ALARM_STOP;
    logic                  ALARM_MODE;
    logic [CNT_W-1:0]      ALARM_PERIOD;
    logic [PRESCALE_W-1:0] ALARM_PRESCALE;
    logic                  ALARM_ACK;
    logic                  ALARM_RUNNING;
    logic [CNT_W-1:0]      ALARM_REMAINING;
    logic                  ALARM_EXPIRE;
    logic                  ALARM_PENDING;
    logic                  ALARM_OVERRUN;

    modport master (
        output ALARM_START, ALARM_STOP, ALARM_MODE, ALARM_PERIOD, ALARM_PRESCALE, ALARM_ACK,
        input  ALARM_RUNNING, ALARM_REMAINING, ALARM_EXPIRE, ALARM_PENDING, ALARM_OVERRUN
    );

    modport slave (
        input  ALARM_START, ALARM_STOP, ALARM_MODE, ALARM_PERIOD, ALARM_PRESCALE, ALARM_ACK,
        output ALARM_RUNNING, ALARM_REMAINING, ALARM_EXPIRE, ALARM_PENDING, ALARM_OVERRUN
    );
endinterface

// File: rtl/timer_alarm_core_prescaler.sv
// Tick divider: one tick every (latched divide + 1) running, enabled cycles.
module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cke_i,
    input  logic                  load,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] div_q;
    logic [PRESCALE_W-1:0] cnt_q;

    assign tick = run && (cnt_q == div_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (cke_i) begin
            if (load) begin
                div_q <= prescale;
                cnt_q <= '0;
            end else if (!run) begin
                cnt_q <= '0;
            end else if (tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/timer_alarm_core.sv
// Countdown alarm: one-shot or auto-reload period, expiry pulse and sticky flags.
module timer_alarm_core
    import timer_alarm_core_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    timer_alarm_core_if.slave   bus
);
    localparam int CNT_W = cnt_w(DATA_W);

    alarm_state_e     state_q;
    logic             mode_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] rem_q;
    logic             expire_q;
    logic             pending_q;
    logic             overrun_q;

    logic tick;
    logic load;
    logic expiry;

    // A zero period is rejected outright, and STOP beats START.
    assign load   = bus.ALARM_START && !bus.ALARM_STOP && (bus.ALARM_PERIOD != '0);
    assign expiry = (state_q == ST_RUN) && tick && (rem_q == CNT_W'(1)) && !load;

    timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .cke_i    (cke_i),
        .load     (load),
        .run      (state_q == ST_RUN),
        .prescale (bus.ALARM_PRESCALE),
        .tick     (tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_ONE_SHOT;
            period_q  <= '0;
            rem_q     <= '0;
            expire_q  <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (!cke_i) begin
            expire_q <= 1'b0;
        end else begin
            expire_q <= expiry;

            // Setting a flag takes priority over a simultaneous ACK.
            if (expiry)             pending_q <= 1'b1;
            else if (bus.ALARM_ACK) pending_q <= 1'b0;
            if (expiry && pending_q) overrun_q <= 1'b1;
            else if (bus.ALARM_ACK)  overrun_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        mode_q   <= bus.ALARM_MODE;
                        period_q <= bus.ALARM_PERIOD;
                        rem_q    <= bus.ALARM_PERIOD;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.ALARM_STOP) begin
                        state_q <= ST_IDLE;
                        if (expiry) rem_q <= (mode_q == MODE_PERIODIC) ? period_q : '0;
                    end else if (load) begin
                        mode_q   <= bus.ALARM_MODE;
                        period_q <= bus.ALARM_PERIOD;
                        rem_q    <= bus.ALARM_PERIOD;
                    end else if (expiry) begin
                        if (mode_q == MODE_PERIODIC) begin
                            rem_q <= period_q;
                        end else begin
                            rem_q   <= '0;
                            state_q <= ST_IDLE;
                        end
                    end else if (tick) begin
                        rem_q <= rem_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ALARM_RUNNING   = (state_q == ST_RUN);
    assign bus.ALARM_REMAINING = rem_q;
    assign bus.ALARM_EXPIRE    = expire_q;
    assign bus.ALARM_PENDING   = pending_q;
    assign bus.ALARM_OVERRUN   = overrun_q;
endmodule
